// File: rtl/calc1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc1_pkg
// Description : Shared command/response codes and FSM state type for the
//               calc1 request/response port.
// Revision    : 1.0 - initial release
// ============================================================================
package calc1_pkg;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;
  localparam logic [0:1] RESP_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2
  } state_t;

endpackage : calc1_pkg
`default_nettype wire

// File: rtl/calc1_alu.sv
`default_nettype none
// ============================================================================
// Module      : calc1_alu
// Description : Combinational calc1 datapath. Maps {cmd, op1, op2} to a
//               response code and result. Bit 0 is the MSB on all buses.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_alu
  import calc1_pkg::*;
#(
  parameter int SHIFT_BITS = 5
) (
  input  logic [0:3]  i_cmd,
  input  logic [0:31] i_op1,
  input  logic [0:31] i_op2,
  output logic [0:1]  o_resp,
  output logic [0:31] o_data
);

  logic [32:0]           w_sum;
  logic [SHIFT_BITS-1:0] w_amt;

  assign w_sum = {1'b0, i_op1} + {1'b0, i_op2};
  assign w_amt = i_op2[32-SHIFT_BITS:31];

  // Decode the command; anything unrecognised reports an error with zero data
  always_comb begin
    o_resp = RESP_ERR;
    o_data = 32'd0;
    case (i_cmd)
      CMD_ADD: begin
        if (!w_sum[32]) begin
          o_resp = RESP_OK;
          o_data = w_sum[31:0];
        end
      end
      CMD_SUB: begin
        if (i_op2 <= i_op1) begin
          o_resp = RESP_OK;
          o_data = i_op1 - i_op2;
        end
      end
      CMD_SHL: begin
        o_resp = RESP_OK;
        o_data = i_op1 << w_amt;
      end
      CMD_SHR: begin
        o_resp = RESP_OK;
        o_data = i_op1 >> w_amt;
      end
      default: begin
        o_resp = RESP_ERR;
        o_data = 32'd0;
      end
    endcase
  end

endmodule : calc1_alu
`default_nettype wire

// File: rtl/calc1_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : calc1_port_responder
// Description : Responder end of one calc1 port. Captures cmd+op1 then op2,
//               waits LATENCY edges and emits a one-cycle response.
//               Optional feature macro: CALC1_DROP_CNT_EN adds drop_cnt, a
//               saturating count of commands dropped while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int SHIFT_BITS = 5
) (
  input  logic        c_clk,
  input  logic        reset_n,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
`ifdef CALC1_DROP_CNT_EN
  ,
  output logic [0:7]  drop_cnt
`endif
);

  localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [0:3]  r_cmd,  w_cmd_nxt;
  logic [0:31] r_op1,  w_op1_nxt;
  logic [0:31] r_op2,  w_op2_nxt;
  logic [3:0]  r_cnt,  w_cnt_nxt;
  logic [0:1]  r_resp, w_resp_nxt;
  logic [0:31] r_data, w_data_nxt;
  logic [0:1]  w_alu_resp;
  logic [0:31] w_alu_data;

  // The ALU always sees the latched request; its result is only sampled when the count expires
  calc1_alu #(
    .SHIFT_BITS (SHIFT_BITS)
  ) u_alu (
    .i_cmd  (r_cmd),
    .i_op1  (r_op1),
    .i_op2  (r_op2),
    .o_resp (w_alu_resp),
    .o_data (w_alu_data)
  );

  // State and datapath registers; reset aborts any in-flight request
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cmd   <= CMD_NOP;
      r_op1   <= 32'd0;
      r_op2   <= 32'd0;
      r_cnt   <= 4'd0;
      r_resp  <= RESP_NONE;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_op1   <= w_op1_nxt;
      r_op2   <= w_op2_nxt;
      r_cnt   <= w_cnt_nxt;
      r_resp  <= w_resp_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state logic; response outputs default to zero so they last exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_op1_nxt   = r_op1;
    w_op2_nxt   = r_op2;
    w_cnt_nxt   = r_cnt;
    w_resp_nxt  = RESP_NONE;
    w_data_nxt  = 32'd0;
    case (r_state)
      IDLE: begin
        if (req_cmd_in != CMD_NOP) begin
          w_cmd_nxt   = req_cmd_in;
          w_op1_nxt   = req_data_in;
          w_state_nxt = OP2;
        end
      end
      OP2: begin
        w_op2_nxt   = req_data_in;
        w_cnt_nxt   = c_CNT_LOAD;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_resp_nxt  = w_alu_resp;
          w_data_nxt  = (w_alu_resp == RESP_OK) ? w_alu_data : 32'd0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_resp = r_resp;
  assign out_data = r_data;
  assign busy     = (r_state == OP2) || (r_state == EXEC);

`ifdef CALC1_DROP_CNT_EN
  logic [0:7] r_drop_cnt;
  logic       w_drop;

  assign w_drop = busy && (req_cmd_in != CMD_NOP);

  // Saturating count of commands that arrived while the port was busy
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule : calc1_port_responder
`default_nettype wire

// File: tb/tb_calc1_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc1_port_responder
// Description : Directed self-checking bench for calc1_port_responder.
//               Honours CALC1_DROP_CNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc1_port_responder;

  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cmd;
  logic [31:0] data_in;
  logic [1:0]  resp;
  logic [31:0] data_out;
  logic        busy;
`ifdef CALC1_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  calc1_port_responder #(
    .LATENCY    (L),
    .SHIFT_BITS (5)
  ) dut (
    .c_clk       (clk),
    .reset_n     (rst_n),
    .req_cmd_in  (cmd),
    .req_data_in (data_in),
    .out_resp    (resp),
    .out_data    (data_out),
    .busy        (busy)
`ifdef CALC1_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  r;
    logic [31:0] d;
  } vec_t;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd = 4'd0;
    data_in = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd = 4'd0;
    data_in = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (resp !== 2'd0) begin errors++; $display("FAIL reset_resp got=%0d want=0", resp); end
    checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef CALC1_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    vec_t v[$];
    v.push_back('{4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000});
    v.push_back('{4'd1, 32'h80000000, 32'h80000000, 2'd2, 32'h00000000});
    v.push_back('{4'd2, 32'd5,        32'd7,        2'd2, 32'h00000000});
    v.push_back('{4'd2, 32'd7,        32'd5,        2'd1, 32'h00000002});
    v.push_back('{4'd5, 32'h00000001, 32'h0000003F, 2'd1, 32'h80000000});
    v.push_back('{4'd6, 32'h80000000, 32'h00000004, 2'd1, 32'h08000000});
    v.push_back('{4'd9, 32'h00000010, 32'h00000020, 2'd2, 32'h00000000});
    v.push_back('{4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000});
    v.push_back('{4'd1, 32'hFFFFFFFF, 32'h00000000, 2'd1, 32'hFFFFFFFF});
    v.push_back('{4'd2, 32'h00000000, 32'h00000000, 2'd1, 32'h00000000});
    v.push_back('{4'd5, 32'h12345678, 32'h00000020, 2'd1, 32'h12345678});
    v.push_back('{4'd6, 32'h80000001, 32'h0000001F, 2'd1, 32'h00000001});
    v.push_back('{4'd5, 32'h000000A5, 32'h00000008, 2'd1, 32'h0000A500});
    v.push_back('{4'd3, 32'h00000004, 32'h00000004, 2'd2, 32'h00000000});
    foreach (v[i]) begin
      @(negedge clk);
      cmd = v[i].c;
      data_in = v[i].a;
      @(negedge clk);
      cmd = 4'd0;
      data_in = v[i].b;
      for (int k = 0; k <= L + 1; k++) begin
        @(negedge clk);
        data_in = 32'd0;
        if (k == L) begin
          checks++; if (resp !== v[i].r) begin errors++; $display("FAIL arith%0d_resp got=%0d want=%0d", i, resp, v[i].r); end
          checks++; if (data_out !== v[i].d) begin errors++; $display("FAIL arith%0d_data got=%h want=%h", i, data_out, v[i].d); end
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arith%0d_busy_resp got=%b want=0", i, busy); end
        end else begin
          checks++; if (resp !== 2'd0 || data_out !== 32'd0) begin errors++; $display("FAIL arith%0d_quiet k=%0d got=%0d/%h want=0/0", i, k, resp, data_out); end
          if (k < L) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arith%0d_busy k=%0d got=%b want=1", i, k, busy); end
          end
        end
      end
    end
  endtask

  task automatic test_busy();
    int seen = 0;
    do_reset();
    @(negedge clk);
    cmd = 4'd1;
    data_in = 32'd2;
    @(negedge clk);
    cmd = 4'd0;
    data_in = 32'd3;
    for (int k = 0; k <= L + 6; k++) begin
      @(negedge clk);
      data_in = 32'd0;
      if (resp !== 2'd0) seen++;
      if (k == L) begin
        checks++; if (resp !== 2'd1 || data_out !== 32'd5) begin errors++; $display("FAIL busy_add got=%0d/%h want=1/5", resp, data_out); end
      end
      cmd = (k == 1) ? 4'd2 : 4'd0;
      if (k == 1) data_in = 32'd9;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL busy_single_resp got=%0d want=1", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle_after got=%b want=0", busy); end
`ifdef CALC1_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got=%0d want=1", drop_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd = 4'd2;
    data_in = 32'd10;
    @(negedge clk);
    cmd = 4'd0;
    data_in = 32'd3;
    for (int k = 0; k <= 2 * L + 3; k++) begin
      @(negedge clk);
      if (k == L) begin
        checks++; if (resp !== 2'd1 || data_out !== 32'd7) begin errors++; $display("FAIL b2b_first got=%0d/%h want=1/7", resp, data_out); end
        cmd = 4'd1;
        data_in = 32'h00000100;
      end else if (k == L + 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
        cmd = 4'd0;
        data_in = 32'h00000023;
      end else begin
        cmd = 4'd0;
        data_in = 32'd0;
        if (k == 2 * L + 2) begin
          checks++; if (resp !== 2'd1 || data_out !== 32'h00000123) begin errors++; $display("FAIL b2b_second got=%0d/%h want=1/123", resp, data_out); end
        end else begin
          checks++; if (resp !== 2'd0) begin errors++; $display("FAIL b2b_quiet k=%0d got=%0d want=0", k, resp); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    cmd = 4'd1;
    data_in = 32'd1;
    @(negedge clk);
    cmd = 4'd0;
    data_in = 32'd1;
    @(negedge clk);
    data_in = 32'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || resp !== 2'd0 || data_out !== 32'd0) begin errors++; $display("FAIL rstmid_immediate got=%b/%0d/%h want=0/0/0", busy, resp, data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clk);
      if (resp !== 2'd0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_resp got=%0d want=0", seen); end
    @(negedge clk);
    cmd = 4'd1;
    data_in = 32'd4;
    @(negedge clk);
    cmd = 4'd0;
    data_in = 32'd5;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      data_in = 32'd0;
      if (k == L) begin
        checks++; if (resp !== 2'd1 || data_out !== 32'd9) begin errors++; $display("FAIL rstmid_next_add got=%0d/%h want=1/9", resp, data_out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_calc1_port_responder
`default_nettype wire
